// File: rtl/ads8688_responder_if.sv
// SPI pins between an ADS8688-style master and the responder.
interface ads8688_responder_if;
  logic sclk;
  logic csn;
  logic mosi;
  logic miso;

  modport master (output sclk, output csn, output mosi, input miso);
  modport slave  (input sclk, input csn, input mosi, output miso);
endinterface

// File: rtl/ads8688_responder.sv
// ADS8688 manual-channel SPI frame responder (device side of the SPI link).
// Optional macro ADS8688_RESP_FRAME_CHECK_EN enables truncated/overlong frame flagging.
module ads8688_responder #(
  parameter int          FRAME_BITS   = 32,
  parameter logic [15:0] CMD_NOOP     = 16'h0000,
  parameter logic [15:0] CMD_MAN_BASE = 16'hC000
) (
  input  logic                 clk,
  input  logic                 arstn,
  ads8688_responder_if.slave   spi,
  output logic                 cmd_valid,
  output logic [15:0]          cmd_word,
  output logic                 sample_req,
  output logic [2:0]           sample_ch,
  input  logic                 sample_valid,
  input  logic [15:0]          sample_data,
  output logic                 data_stale,
  output logic                 frame_err
);

  localparam logic [5:0]  FULL_CNT = 6'(FRAME_BITS);
  localparam logic [15:0] MAN_MASK = 16'hE3FF;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;
  state_t state_reg, state_next;

  logic [2:0] async_in;
  logic [2:0] sync_s;
  assign async_in = {spi.sclk, spi.csn, spi.mosi};

  // csn resets to the "low" side so a frame already running at reset release is ignored
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [1:0] ff_reg;
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) ff_reg <= 2'b00;
        else        ff_reg <= {ff_reg[0], async_in[gi]};
      end
      assign sync_s[gi] = ff_reg[1];
    end
  endgenerate

  logic sclk_s, csn_s, mosi_s;
  logic sclk_d_reg, csn_d_reg;
  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  assign sclk_s    = sync_s[2];
  assign csn_s     = sync_s[1];
  assign mosi_s    = sync_s[0];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign csn_rise  = csn_s & ~csn_d_reg;
  assign csn_fall  = ~csn_s & csn_d_reg;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclk_d_reg <= 1'b0;
      csn_d_reg  <= 1'b0;
    end else begin
      sclk_d_reg <= sclk_s;
      csn_d_reg  <= csn_s;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_reg <= WAIT_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_IDLE: if (csn_s)    state_next = IDLE;
      IDLE:      if (csn_fall) state_next = SHIFT;
      SHIFT:     if (csn_rise) state_next = DONE;
      default:                 state_next = IDLE;
    endcase
  end

  logic load_frame, shift_en, frame_done;
  always_comb begin
    load_frame = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:    load_frame = csn_fall;
      SHIFT:   shift_en   = 1'b1;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  logic [31:0] tx_shift_reg, rx_shift_reg;
  logic [5:0]  bit_cnt_reg;
  logic [15:0] result_reg, cmd_word_reg;
  logic        pending_reg, cmd_valid_reg, sample_req_reg, data_stale_reg, miso_reg;
  logic [2:0]  sample_ch_reg;
  logic        frame_ok, is_man, is_noop, req_now;

  assign is_man  = (rx_shift_reg[31:16] & MAN_MASK) == (CMD_MAN_BASE & MAN_MASK);
  assign is_noop = rx_shift_reg[31:16] == CMD_NOOP;
  assign req_now = frame_done & frame_ok & (is_man | is_noop);

`ifdef ADS8688_RESP_FRAME_CHECK_EN
  // bit_cnt saturates, so overlong frames need their own sticky marker
  logic ovf_reg, frame_err_reg;
  assign frame_ok  = (bit_cnt_reg == FULL_CNT) & ~ovf_reg;
  assign frame_err = frame_err_reg;
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ovf_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= frame_done & ~frame_ok;
      if (load_frame)
        ovf_reg <= 1'b0;
      else if (shift_en && sclk_rise && bit_cnt_reg == FULL_CNT)
        ovf_reg <= 1'b1;
    end
  end
`else
  assign frame_ok  = bit_cnt_reg == FULL_CNT;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_shift_reg   <= '0;
      rx_shift_reg   <= '0;
      bit_cnt_reg    <= '0;
      result_reg     <= '0;
      pending_reg    <= 1'b0;
      cmd_word_reg   <= '0;
      cmd_valid_reg  <= 1'b0;
      sample_req_reg <= 1'b0;
      sample_ch_reg  <= '0;
      data_stale_reg <= 1'b0;
      miso_reg       <= 1'b0;
    end else begin
      cmd_valid_reg  <= frame_done & frame_ok;
      sample_req_reg <= req_now;
      data_stale_reg <= load_frame & pending_reg;
      miso_reg       <= ~csn_s & tx_shift_reg[31];
      if (load_frame) begin
        tx_shift_reg <= {16'h0000, pending_reg ? 16'h0000 : result_reg};
        bit_cnt_reg  <= '0;
      end else if (shift_en) begin
        if (sclk_rise && bit_cnt_reg != FULL_CNT) begin
          rx_shift_reg <= {rx_shift_reg[30:0], mosi_s};
          bit_cnt_reg  <= bit_cnt_reg + 6'd1;
        end
        if (sclk_fall)
          tx_shift_reg <= {tx_shift_reg[30:0], 1'b0};
      end
      if (frame_done && frame_ok) begin
        cmd_word_reg <= rx_shift_reg[31:16];
        if (is_man)
          sample_ch_reg <= rx_shift_reg[28:26];
      end
      // a result arriving alongside a fresh request belongs to the old one and is dropped
      if (req_now)
        pending_reg <= 1'b1;
      else if (sample_valid && pending_reg && !sample_req_reg) begin
        result_reg  <= sample_data;
        pending_reg <= 1'b0;
      end
    end
  end

  assign spi.miso   = miso_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign cmd_word   = cmd_word_reg;
  assign sample_req = sample_req_reg;
  assign sample_ch  = sample_ch_reg;
  assign data_stale = data_stale_reg;

endmodule

// File: tb/tb_ads8688_responder.sv
// Randomised scoreboard bench for ads8688_responder against a frame-level model.
module tb_ads8688_responder;

  logic        clk = 1'b0;
  logic        arstn;
  logic        cmd_valid, sample_req, data_stale, frame_err;
  logic [15:0] cmd_word;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic [15:0] sample_data;

  always #5 clk = ~clk;

  ads8688_responder_if bus();

  ads8688_responder dut (
    .clk(clk), .arstn(arstn), .spi(bus.slave),
    .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .sample_req(sample_req), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .data_stale(data_stale), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [15:0] cmd;
    logic        req;
    logic [2:0]  ch;
  } cmd_exp_t;

  cmd_exp_t    cmd_q[$];
  logic [31:0] miso_q[$];
  int checks = 0, fails = 0;
  int stale_exp = 0, stale_obs = 0, err_exp = 0, err_obs = 0;
  int csn_hi = 0;
  bit reset_frame = 1'b0;

  logic [15:0] m_result;
  logic        m_pending;
  logic [2:0]  m_ch;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit man_match(input logic [15:0] c, output logic [2:0] ch);
    ch = 3'd0;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] v;
      v = 16'hC000 | (16'(k) << 10);
      if (c == v) begin
        ch = 3'(k);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // command / request scoreboard
  always @(negedge clk) begin
    if (arstn) begin
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL cmd_valid_unexpected: got cmd_word %h expected no frame", cmd_word);
        end else begin
          cmd_exp_t e;
          e = cmd_q.pop_front();
          check("cmd_word", 32'(cmd_word), 32'(e.cmd));
          check("req_ch", 32'({sample_req, sample_ch}), 32'({e.req, e.ch}));
        end
      end else if (sample_req) begin
        checks++; fails++;
        $display("FAIL sample_req_alone: got 1 expected 0");
      end
      if (data_stale) stale_obs++;
      if (frame_err)  err_obs++;
      if (bus.csn) csn_hi++; else csn_hi = 0;
      if (csn_hi >= 6)  check("miso_idle", 32'(bus.miso), 32'd0);
      if (reset_frame)  check("miso_reset_frame", 32'(bus.miso), 32'd0);
    end
  end

  // miso scoreboard: first 32 bits of each frame
  int          cap_n = 0;
  logic [31:0] cap = '0;
  always @(posedge bus.sclk) begin
    if (!bus.csn && cap_n < 32) begin
      cap = {cap[30:0], bus.miso};
      cap_n++;
    end
  end
  always @(posedge bus.csn) begin
    if (miso_q.size() > 0) begin
      logic [31:0] e;
      e = miso_q.pop_front();
      if (cap_n > 0) check("miso_frame", cap, e >> (32 - cap_n));
    end
    cap = '0;
    cap_n = 0;
  end

  task automatic do_frame(input logic [15:0] cmd, input int n, output bit req);
    logic [31:0] word;
    logic [2:0]  ch;
    bit          complete;
    word = {cmd, 16'($urandom)};
    req = 1'b0;
    miso_q.push_back({16'h0000, m_pending ? 16'h0000 : m_result});
    if (m_pending) stale_exp++;
`ifdef ADS8688_RESP_FRAME_CHECK_EN
    complete = (n == 32);
    if (!complete) err_exp++;
`else
    complete = (n >= 32);
`endif
    if (complete) begin
      if (man_match(cmd, ch)) begin
        m_ch = ch;
        req = 1'b1;
      end else if (cmd == 16'h0000) begin
        req = 1'b1;
      end
      if (req) m_pending = 1'b1;
      cmd_q.push_back({cmd, req, m_ch});
    end
    $display("frame cmd=%h bits=%0d expect_req=%0d ch=%0d", cmd, n, req, m_ch);
    @(negedge clk);
    bus.csn = 1'b0;
    bus.mosi = word[31];
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b0;
      bus.mosi = (i < 31) ? word[30 - i] : 1'b0;
      repeat (8) @(negedge clk);
    end
    bus.csn = 1'b1;
  endtask

  task automatic give_sample(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data = d;
    @(negedge clk);
    sample_valid = 1'b0;
    $display("sample data=%h accepted=%0d", d, m_pending);
    if (m_pending) begin
      m_result = d;
      m_pending = 1'b0;
    end
  endtask

  // result presented in the same cycle as a new request is dropped
  task automatic collide(input logic [15:0] d);
    int k;
    k = 0;
    while (!sample_req && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("collide_req_seen", 32'(sample_req), 32'd1);
    sample_valid = 1'b1;
    sample_data = d;
    @(negedge clk);
    sample_valid = 1'b0;
    $display("collide data=%h dropped", d);
  endtask

  initial begin
    bit          req;
    logic [15:0] cmd;
    int          n, act;
    arstn = 1'b0;
    bus.csn = 1'b0;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    m_result = '0;
    m_pending = 1'b0;
    m_ch = '0;
    miso_q.push_back(32'd0);
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus.miso, cmd_valid, cmd_word, sample_req, sample_ch, data_stale, frame_err}), 32'd0);
    reset_frame = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) arstn = 1'b1;
      bus.mosi = 1'($urandom);
      bus.sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    bus.csn = 1'b1;
    repeat (20) @(negedge clk);
    reset_frame = 1'b0;

    do_frame(16'hC800, 32, req); repeat (12) @(negedge clk);
    give_sample(16'hA5C3);       repeat (4) @(negedge clk);
    do_frame(16'h0000, 32, req); repeat (12) @(negedge clk);
    do_frame(16'hCC00, 32, req); repeat (12) @(negedge clk);
    give_sample(16'h5A3C);       repeat (4) @(negedge clk);
    do_frame(16'h8500, 32, req); repeat (12) @(negedge clk);
    give_sample(16'h1234);
    do_frame(16'hC400, 20, req); repeat (12) @(negedge clk);
    do_frame(16'hC400, 0, req);  repeat (12) @(negedge clk);
    do_frame(16'hC400, 34, req); repeat (12) @(negedge clk);
    give_sample(16'h0F0F);
    do_frame(16'hD000, 32, req);
    collide(16'hBEEF);           repeat (12) @(negedge clk);
    do_frame(16'h0000, 32, req); repeat (12) @(negedge clk);
    give_sample(16'h7E81);

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0:       cmd = 16'hC000 | (16'($urandom_range(0, 7)) << 10);
        1:       cmd = 16'h0000;
        2:       cmd = 16'($urandom);
        default: cmd = 16'hC000 | (16'($urandom_range(0, 7)) << 10) | 16'($urandom_range(1, 1023));
      endcase
      case ($urandom_range(0, 9))
        7:       n = $urandom_range(0, 31);
        8:       n = 33 + $urandom_range(0, 2);
        default: n = 32;
      endcase
      act = $urandom_range(0, 3);
      do_frame(cmd, n, req);
      if (act == 2 && req) collide(16'($urandom));
      repeat (12) @(negedge clk);
      if (act == 1 || act == 3) give_sample(16'($urandom));
    end

    repeat (30) @(negedge clk);
    check("data_stale_count", 32'(stale_obs), 32'(stale_exp));
    check("frame_err_count", 32'(err_obs), 32'(err_exp));
    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("miso_queue_drained", 32'(miso_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
